// File: rtl/uart_tx_byte_feeder.sv
// Byte FIFO that feeds the UART transmitter one frame at a time.
// TxByte is held from the pop until the next pop because the transmitter samples it on every bit.
module uart_tx_byte_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  WrEn,
    input  logic [7:0]            WrData,
    output logic                  Full,
    output logic                  Empty,
    output logic [DEPTH_LOG2:0]   Level,
    output logic                  Overflow,
    output logic                  Idle,
    output logic                  TxSend,
    output logic [7:0]            TxByte,
    input  logic                  TxBusy
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t                 state;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wrPtr;
    logic [DEPTH_LOG2-1:0]  rdPtr;
    logic                   wrAcc;
    logic                   pop;

    assign Full  = (Level == DEPTH_LVL);
    assign Empty = (Level == '0);
    assign Idle  = Empty && (state == IDLE);
    assign wrAcc = WrEn && !Full;
    assign pop   = (state == IDLE) && !Empty;

    always_ff @(posedge CLK) begin
        if (wrAcc) mem[wrPtr] <= WrData;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            Level    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (wrAcc) wrPtr <= wrPtr + 1'b1;
            if (pop)   rdPtr <= rdPtr + 1'b1;
            if (WrEn && Full) Overflow <= 1'b1;
            case ({wrAcc, pop})
                2'b10:   Level <= Level + 1'b1;
                2'b01:   Level <= Level - 1'b1;
                default: Level <= Level;
            endcase
        end
    end

    // TxBusy is ignored in SEND: the transmitter raises it combinationally from TxSend.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= IDLE;
            TxSend <= 1'b0;
            TxByte <= 8'h00;
        end else begin
            TxSend <= 1'b0;
            case (state)
                IDLE: if (!Empty) begin
                    TxByte <= mem[rdPtr];
                    TxSend <= 1'b1;
                    state  <= SEND;
                end
                SEND:    state <= WAIT;
                WAIT:    if (!TxBusy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
